// File: rtl/pwm_count_compare.sv
// pwm_count_compare: compares an upstream wrap counter against a duty threshold applied only at wrap, with period-aligned start/stop.
// Optional count-continuity checker enabled by defining PWM_COUNT_CHECK_EN.
module pwm_count_compare #(
  parameter int WIDTH  = 4,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  count,
  input  logic              enable,
  input  logic [WIDTH:0]    duty_in,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              pwm_out,
  output logic              period_done,
  output logic [PCNT_W-1:0] period_cnt,
  output logic              busy,
  output logic              count_err
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN, DRAIN} state_t;
  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH:0]   FULL = {1'b1, {WIDTH{1'b0}}};
  state_t state_q, state_d;
  logic pwm_q, pwm_d, done_q, done_d, busy_q, busy_d, pend_q, pend_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [WIDTH:0] act_q, act_d, pending_q, pending_d;
  logic wrap, active, arm, xfer;
  assign wrap   = count == MAX;
  assign active = state_q == RUN || state_q == DRAIN;
  assign arm    = state_q == IDLE && enable;
  assign xfer   = duty_valid && !pend_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = enable ? ARMED : IDLE;
      ARMED:   state_d = !enable ? IDLE : wrap ? RUN : ARMED;
      RUN:     state_d = enable ? RUN : DRAIN;
      DRAIN:   state_d = enable ? RUN : wrap ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // a transfer in a wrap cycle only fills the pending slot; it applies at the next wrap
  always_comb begin
    pwm_d     = active && ({1'b0, count} < act_q);
    done_d    = active && wrap;
    pcnt_d    = arm ? '0 : done_d ? pcnt_q + PCNT_W'(1) : pcnt_q;
    busy_d    = state_d != IDLE;
    act_d     = (wrap && pend_q) ? pending_q : act_q;
    pend_d    = xfer ? 1'b1 : wrap ? 1'b0 : pend_q;
    pending_d = xfer ? ((duty_in > FULL) ? FULL : duty_in) : pending_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pwm_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      pend_q    <= 1'b0;
      pcnt_q    <= '0;
      act_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pwm_q     <= pwm_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      pend_q    <= pend_d;
      pcnt_q    <= pcnt_d;
      act_q     <= act_d;
      pending_q <= pending_d;
    end
  end
  assign duty_ready  = !pend_q;
  assign pwm_out     = pwm_q;
  assign period_done = done_q;
  assign period_cnt  = pcnt_q;
  assign busy        = busy_q;
`ifdef PWM_COUNT_CHECK_EN
  logic [WIDTH-1:0] prev_count_q, prev_count_d;
  logic err_q, err_d, first_q, first_d;
  // first ARMED cycle is skipped because count was unconstrained while idle
  always_comb begin
    prev_count_d = count;
    first_d      = arm;
    err_d        = arm ? 1'b0 :
                   (state_q != IDLE && !first_q && count != prev_count_q + WIDTH'(1)) ? 1'b1 : err_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_count_q <= '0;
      first_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      prev_count_q <= prev_count_d;
      first_q      <= first_d;
      err_q        <= err_d;
    end
  end
  assign count_err = err_q;
`else
  assign count_err = 1'b0;
`endif
endmodule

// File: tb/tb_pwm_count_compare.sv
// tb_pwm_count_compare: directed bench for pwm_count_compare driven by a local 4-bit up counter.
module tb_pwm_count_compare;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, duty_valid = 1'b0, skip = 1'b0;
  logic [4:0] duty_in = 5'd0;
  logic [3:0] cnt;
  logic duty_ready, pwm_out, period_done, busy, count_err;
  logic [7:0] period_cnt;
  int vecs = 0, errs = 0;
  pwm_count_compare #(.WIDTH(4), .PCNT_W(8)) dut (
    .clk(clk), .rst(rst), .count(cnt), .enable(enable), .duty_in(duty_in),
    .duty_valid(duty_valid), .duty_ready(duty_ready), .pwm_out(pwm_out),
    .period_done(period_done), .period_cnt(period_cnt), .busy(busy), .count_err(count_err)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk or posedge rst) cnt <= rst ? 4'd0 : cnt + (skip ? 4'd3 : 4'd1);
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_cnt(input logic [3:0] v);
    for (int n = 0; n < 40 && cnt !== v; n++) step;
    chk("sync", 32'(cnt), 32'(v));
  endtask
  // entered just after a wrap (count 0 visible); walks one full period
  task automatic check_period(input int d, input int pc, input int rdy, input int late);
    chk("period_start", 32'(cnt), 32'd0);
    for (int c = 1; c < 16; c++) begin
      step;
      duty_valid = 1'b0;
      chk("pwm", 32'(pwm_out), 32'((c - 1) < d));
      chk("pdone_mid", 32'(period_done), 32'd0);
      chk("ready", 32'(duty_ready), 32'(rdy));
      if (c == 15 && late >= 0) begin
        duty_valid = 1'b1;
        duty_in = 5'(late);
      end
    end
    step;
    duty_valid = 1'b0;
    chk("pwm_wrap", 32'(pwm_out), 32'(15 < d));
    chk("pdone_wrap", 32'(period_done), 32'd1);
    chk("pcnt", 32'(period_cnt), 32'(pc));
    chk("ready_wrap", 32'(duty_ready), 32'(late < 0));
  endtask
  initial begin
    step;
    step;
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pcnt", 32'(period_cnt), 32'd0);
    chk("rst_pdone", 32'(period_done), 32'd0);
    chk("rst_err", 32'(count_err), 32'd0);
    rst = 1'b0;
    chk("rel_ready", 32'(duty_ready), 32'd1);
    enable = 1'b1;
    step;
    chk("armed_busy", 32'(busy), 32'd1);
    wait_cnt(4'd15);
    duty_valid = 1'b1;
    duty_in = 5'd5;
    step;
    duty_valid = 1'b0;
    chk("run_pdone", 32'(period_done), 32'd0);
    chk("run_pwm", 32'(pwm_out), 32'd0);
    chk("run_ready", 32'(duty_ready), 32'd0);
    check_period(0, 1, 0, -1);
    duty_valid = 1'b1;
    duty_in = 5'd16;
    check_period(5, 2, 0, -1);
    duty_valid = 1'b1;
    duty_in = 5'd0;
    check_period(16, 3, 0, -1);
    check_period(0, 4, 1, 10);
    check_period(0, 5, 0, -1);
    duty_valid = 1'b1;
    duty_in = 5'd20;
    check_period(10, 6, 0, -1);
    check_period(16, 7, 1, -1);
    wait_cnt(4'd7);
    enable = 1'b0;
    for (int c = 8; c < 16; c++) begin
      step;
      chk("drain_pwm", 32'(pwm_out), 32'd1);
      chk("drain_busy", 32'(busy), 32'd1);
    end
    step;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_pwm", 32'(pwm_out), 32'd1);
    chk("stop_pdone", 32'(period_done), 32'd1);
    chk("stop_pcnt", 32'(period_cnt), 32'd8);
    step;
    chk("idle_pwm", 32'(pwm_out), 32'd0);
    chk("idle_pdone", 32'(period_done), 32'd0);
    chk("idle_pcnt", 32'(period_cnt), 32'd8);
    enable = 1'b1;
    step;
    chk("rearm_pcnt", 32'(period_cnt), 32'd0);
    wait_cnt(4'd15);
    step;
    chk("rerun_pwm", 32'(pwm_out), 32'd0);
    chk("rerun_pdone", 32'(period_done), 32'd0);
    step;
    chk("rerun_pwm1", 32'(pwm_out), 32'd1);
    enable = 1'b0;
    for (int c = 2; c < 16; c++) begin
      step;
      chk("noglitch_pwm", 32'(pwm_out), 32'd1);
      chk("noglitch_busy", 32'(busy), 32'd1);
      if (c == 3) enable = 1'b1;
      if (c == 15) enable = 1'b0;
    end
    step;
    chk("dropw_pdone", 32'(period_done), 32'd1);
    chk("dropw_pcnt", 32'(period_cnt), 32'd1);
    chk("dropw_busy", 32'(busy), 32'd1);
    for (int c = 1; c < 16; c++) begin
      step;
      chk("dropw_drain", 32'(busy), 32'd1);
    end
    step;
    chk("dropw_idle", 32'(busy), 32'd0);
    chk("dropw_pcnt2", 32'(period_cnt), 32'd2);
    enable = 1'b1;
    wait_cnt(4'd15);
    step;
    wait_cnt(4'd15);
    step;
    chk("prer_pcnt", 32'(period_cnt), 32'd1);
    duty_valid = 1'b1;
    duty_in = 5'd3;
    step;
    duty_valid = 1'b0;
    chk("prer_ready", 32'(duty_ready), 32'd0);
    step;
    chk("prer_pwm", 32'(pwm_out), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_pwm", 32'(pwm_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_pcnt", 32'(period_cnt), 32'd0);
    #2;
    rst = 1'b0;
    chk("arst_ready", 32'(duty_ready), 32'd1);
    wait_cnt(4'd15);
    step;
    check_period(0, 1, 1, -1);
`ifdef PWM_COUNT_CHECK_EN
    wait_cnt(4'd6);
    skip = 1'b1;
    step;
    skip = 1'b0;
    chk("jump_cnt", 32'(cnt), 32'd9);
    chk("jump_err0", 32'(count_err), 32'd0);
    step;
    chk("jump_err1", 32'(count_err), 32'd1);
    enable = 1'b0;
    wait_cnt(4'd15);
    step;
    step;
    chk("sticky_busy", 32'(busy), 32'd0);
    chk("sticky_err", 32'(count_err), 32'd1);
    enable = 1'b1;
    step;
    chk("clear_err", 32'(count_err), 32'd0);
`else
    chk("err_tied", 32'(count_err), 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
